// File: rtl/freq_meas_scheduler_pkg.sv
// freq_meas_pkg: shared types and defaults for the frequency-measurement
// scheduler slice.
//   state_t            - scheduler FSM states
//   DEF_*              - default parameter values used by the top level
package freq_meas_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_OUT    = 3'd4
   } state_t;

   localparam int DEF_NUM_CH     = 4;
   localparam int DEF_CNT_W      = 32;
   localparam int DEF_GATE_W     = 32;
   localparam int DEF_SETTLE_CYC = 4;
   localparam int DEF_TO_MARGIN  = 16;

endpackage

// File: rtl/freq_meas_scheduler_if.sv
// freq_meas_scheduler_if: result port of the measurement scheduler.
//   res_valid   - result available (master drives)
//   res_ready   - consumer ready (slave drives)
//   res_ch      - channel the result belongs to
//   res_count   - measured count (0 on timeout)
//   res_timeout - engine did not finish within gate + margin
// Handshake: a result transfers on every clk edge where res_valid && res_ready
// are both high; once res_valid rises, res_valid and all res_* fields hold
// unchanged until that transfer, and res_valid never depends on res_ready.
interface freq_meas_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32
);
   localparam int CH_W = $clog2(NUM_CH);

   logic             res_valid;
   logic             res_ready;
   logic [CH_W-1:0]  res_ch;
   logic [CNT_W-1:0] res_count;
   logic             res_timeout;

   modport master (
      output res_valid,
      output res_ch,
      output res_count,
      output res_timeout,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_ch,
      input  res_count,
      input  res_timeout,
      output res_ready
   );
endinterface

// File: rtl/freq_meas_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       - request vector
//   ptr       - highest-priority channel index for this pick
//   grant     - one-hot grant (all zero when req is zero)
//   grant_idx - encoded grant (0 when req is zero)
// Searches req starting at ptr and wrapping; the pointer register lives
// in the parent.
module rr_arbiter #(
   parameter int  NUM_CH = 4,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_idx
);

   logic found;
   int   idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (int'(ptr) + i) % NUM_CH;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = CH_W'(idx);
         end
      end
   end

endmodule

// File: rtl/freq_meas_scheduler.sv
// freq_meas_scheduler: shares one frequency-counting engine among NUM_CH
// channels. Picks a requester round-robin, switches the engine mux, waits
// a settle interval, starts a gated count, captures the count or a
// timeout, and offers it on the result port.
//   clk, reset       - clock, asynchronous active-high reset
//   ch_req / ch_ack  - per-channel level request / one-cycle accept pulse
//   gate_cycles      - requested gate length (0 is treated as 1)
//   eng_sel          - engine input-mux select (current grant)
//   eng_start        - one-cycle engine start pulse
//   eng_gate         - gate length presented to the engine
//   eng_done         - engine completion pulse, eng_count valid with it
//   res              - result port (see freq_meas_scheduler_if)
//   busy             - high outside IDLE
//   dbg_state        - FSM state
//   dbg_rr_ptr       - round-robin pointer
module freq_meas_scheduler
   import freq_meas_pkg::*;
#(
   parameter int  NUM_CH     = DEF_NUM_CH,
   parameter int  CNT_W      = DEF_CNT_W,
   parameter int  GATE_W     = DEF_GATE_W,
   parameter int  SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int  TO_MARGIN  = DEF_TO_MARGIN,
   localparam int CH_W       = $clog2(NUM_CH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_CH-1:0]     ch_req,
   output logic [NUM_CH-1:0]     ch_ack,
   input  logic [GATE_W-1:0]     gate_cycles,
   output logic [CH_W-1:0]       eng_sel,
   output logic                  eng_start,
   output logic [GATE_W-1:0]     eng_gate,
   input  logic                  eng_done,
   input  logic [CNT_W-1:0]      eng_count,
   freq_meas_scheduler_if.master res,
   output logic                  busy,
   output state_t                dbg_state,
   output logic [CH_W-1:0]       dbg_rr_ptr
);

   localparam int TMR_W = GATE_W + 1;
   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SET_W-1:0] SETTLE_LOAD =
      (SETTLE_CYC > 0) ? SET_W'(SETTLE_CYC - 1) : '0;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
   localparam bit NO_SETTLE = (SETTLE_CYC == 0);

   state_t            state, state_next;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   grant_q;
   logic [NUM_CH-1:0] grant_oh_q;
   logic [SET_W-1:0]  settle_cnt;
   logic [TMR_W-1:0]  timer;

   logic [NUM_CH-1:0] arb_grant;
   logic [CH_W-1:0]   arb_idx;
   logic [GATE_W-1:0] gate_eff;
   logic [TMR_W:0]    to_sum;
   logic [TMR_W-1:0]  to_load;
   logic              timer_expired;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req       (ch_req),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   assign gate_eff = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;

   // Timeout load is eng_gate + TO_MARGIN, one bit wider than the gate and
   // clamped to all-ones instead of wrapping to a short timeout.
   assign to_sum  = {2'b00, eng_gate} + $unsigned((TMR_W + 1)'(TO_MARGIN));
   assign to_load = to_sum[TMR_W] ? {TMR_W{1'b1}} : to_sum[TMR_W-1:0];

   // Timer holds the WAIT cycles still allowed, including the current one.
   assign timer_expired = (timer <= TMR_W'(1));

   assign eng_sel    = grant_q;
   assign eng_start  = (state == ST_START);
   assign busy       = (state != ST_IDLE);
   assign dbg_state  = state;
   assign dbg_rr_ptr = rr_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (|ch_req) state_next = NO_SETTLE ? ST_START : ST_SETTLE;
         ST_SETTLE: if (settle_cnt == '0) state_next = ST_START;
         ST_START:  state_next = ST_WAIT;
         ST_WAIT:   if (eng_done || timer_expired) state_next = ST_OUT;
         ST_OUT:    if (res.res_ready) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr          <= '0;
         grant_q         <= '0;
         grant_oh_q      <= '0;
         settle_cnt      <= '0;
         timer           <= '0;
         eng_gate        <= '0;
         ch_ack          <= '0;
         res.res_valid   <= 1'b0;
         res.res_ch      <= '0;
         res.res_count   <= '0;
         res.res_timeout <= 1'b0;
      end else begin
         ch_ack <= '0;

         // The gate is latched on entry to START so the engine sees a stable
         // value together with eng_start.
         if (state_next == ST_START && state != ST_START) eng_gate <= gate_eff;

         case (state)
            ST_IDLE: begin
               if (|ch_req) begin
                  grant_q    <= arb_idx;
                  grant_oh_q <= arb_grant;
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
            end
            ST_START: begin
               timer <= to_load;
            end
            ST_WAIT: begin
               // eng_done wins over an expiry in the same cycle.
               if (eng_done) begin
                  res.res_valid   <= 1'b1;
                  res.res_ch      <= grant_q;
                  res.res_count   <= eng_count;
                  res.res_timeout <= 1'b0;
               end else if (timer_expired) begin
                  res.res_valid   <= 1'b1;
                  res.res_ch      <= grant_q;
                  res.res_count   <= '0;
                  res.res_timeout <= 1'b1;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            ST_OUT: begin
               if (res.res_ready) begin
                  res.res_valid <= 1'b0;
                  ch_ack        <= grant_oh_q;
                  rr_ptr        <= (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/freq_meas_scheduler.md
# freq_meas_scheduler

Round-robin measurement scheduler that shares one frequency-counting engine among `NUM_CH` input channels. It selects a requesting channel, drives the engine's input mux, and waits a settle interval. It then starts a gated count with the configured gate length, captures the result or a timeout, and presents it on a valid/ready result port. It sits between the channel front-ends and the single counting engine, which owns the pulse and gate counters.

## Interface
- `NUM_CH`, 4: number of measured channels (2..16).
- `CNT_W`, 32: width of the engine count and the result count.
- `GATE_W`, 32: width of the gate length in clk cycles.
- `SETTLE_CYC`, 4: idle cycles after a mux switch before the engine starts (0 allowed).
- `TO_MARGIN`, 16: extra cycles beyond the gate length before a timeout is declared.

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `ch_req` in NUM_CH: level request per channel; held until `ch_ack`.
- `ch_ack` out NUM_CH: one-cycle one-hot pulse when that channel's result is accepted.
- `gate_cycles` in GATE_W: gate length, sampled in START.
- `eng_sel` out $clog2(NUM_CH): engine input-mux select.
- `eng_start` out 1: one-cycle start pulse to the engine.
- `eng_gate` out GATE_W: latched gate length; stable from START to the end of WAIT.
- `eng_done` in 1: engine completion pulse.
- `eng_count` in CNT_W: engine count, valid with `eng_done`.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumer ready.
- `res_ch` out $clog2(NUM_CH): channel of the result.
- `res_count` out CNT_W: measured count.
- `res_timeout` out 1: engine did not finish in time; `res_count` = 0.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:**
  - IDLE: if `ch_req` ≠ 0, grant the next requester at or after `rr_ptr` (wrapping) and go to SETTLE. Otherwise stay in IDLE.
  - SETTLE: `eng_sel` = grant; count down `SETTLE_CYC`, then go to START. If `SETTLE_CYC` = 0, go straight to START.
  - START: latch `eng_gate` = max(`gate_cycles`, 1); pulse `eng_start`; load the timeout counter with `eng_gate` + `TO_MARGIN`; go to WAIT.
  - WAIT: on `eng_done`, capture `eng_count` with `res_timeout` = 0. If the timer expires first, capture count 0 with `res_timeout` = 1. Either way, go to OUT.
  - OUT: hold `res_valid` until `res_valid && res_ready`. On that handshake, pulse `ch_ack`[grant], set `rr_ptr` = grant+1 mod `NUM_CH`, and go to IDLE.
- **Requests:** a request withdrawn after grant does not abort the measurement; the result is still produced.
- **Stray engine pulses:** `eng_done` outside WAIT is ignored.
- **Timeout arithmetic:** the sum is computed at GATE_W+1 bits and saturates; no wrap.
- **Result stability:** `res_*` outputs are registered and stable while `res_valid` = 1 and not yet accepted.
- **Reset values:** state IDLE, `rr_ptr` 0. All outputs 0: `eng_sel`, `eng_start`, `eng_gate`, `ch_ack`, `res_valid`, `res_ch`, `res_count`, `res_timeout`, `busy`.
- **Reset mid-operation:** reset returns to IDLE immediately. No `ch_ack` or result is emitted for the aborted channel; the engine is expected to be reset by the same `reset`.

## Timing
- Request seen in IDLE at cycle T: `eng_sel` valid at T+1; `eng_start` at T+1+`SETTLE_CYC`.
- `eng_done` at cycle D: `res_valid` = 1 from D+1.
- Handshake at cycle H: `ch_ack` pulses at H+1; IDLE at H+1; the next grant is possible at H+1 (from IDLE evaluation), with `eng_sel` updated at H+2.
- The timeout fires when `eng_gate` + `TO_MARGIN` WAIT cycles elapse without `eng_done`. If `eng_done` arrives on the expiry cycle, `eng_done` wins.
- At most one measurement is in flight; there is no pipelining across channels.

## Structure
- **Package `freq_meas_pkg`:** state enum (IDLE, SETTLE, START, WAIT, OUT), default widths, and the `TO_MARGIN` default.
- **Sub-module `rr_arbiter`** (`NUM_CH`): inputs `req`, `ptr`; outputs one-hot `grant` and encoded `grant_idx`. Combinational; the pointer register stays in the top level.

## Test plan
- `ch_req` = 4'b0100, `gate_cycles` = 100, `SETTLE_CYC` = 4, engine returns 37 after 100 cycles → `eng_sel` = 2, `eng_start` 5 cycles after the request, `res_ch` = 2, `res_count` = 37, `res_timeout` = 0, `ch_ack` = 4'b0100.
- `ch_req` = 4'b1111 held, `res_ready` always 1 → service order 0, 1, 2, 3, 0, each `ch_ack` a single pulse.
- Engine never pulses `eng_done`, `gate_cycles` = 10 → `res_valid` 26 WAIT cycles after START, with `res_timeout` = 1 and `res_count` = 0.
- `gate_cycles` = 0 → `eng_gate` = 1. `res_ready` held low for 20 cycles → `res_*` stable throughout and no new `eng_start`.
- `reset` asserted during WAIT, then released → all outputs 0, `rr_ptr` 0, no `ch_ack`. With `ch_req` = 4'b0011 after release → channel 0 is served first.
